cpc_rom_loader: RTL
===================

Name: cpc_rom_loader

Overview:
- Download-to-SDRAM write sequencer between the HPS ioctl download stream and the SDRAM boot write port (boot_wr/boot_a/boot_bank/boot_dout).
- Maps system ROM images (index 0) and expansion ROMs (e?? extension) onto fixed 16 KiB SDRAM pages, optionally duplicating into both model banks.
- Throttles the HPS with ioctl_wait and maintains rom_map, the bitmap of populated expansion ROM pages read by the CPU ROM mask logic.

Parameters:
- PAGE_BADEXT, 9'h1EE, page used when the extension digits are malformed
- PAGE_MF2, 9'h1FF, Multiface 2 ROM page; also the post-combo base page

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high; connect to system/user reset only, never to the download-derived reset
- ce_ref  in  1  SDRAM reference strobe; one boot write slot per ce_ref
- ioctl_download  in  1  download active
- ioctl_wr  in  1  byte valid strobe, one clk_sys
- ioctl_addr  in  25  byte offset in file
- ioctl_dout  in  8  byte data
- ioctl_index  in  8  menu/file index
- ioctl_file_ext  in  32  extension, ASCII, last char in [7:0]
- ioctl_wait  out  1  back-pressure to HPS
- boot_wr  out  1  SDRAM write request
- boot_a  out  23  {page[8:0], offset[13:0]}
- boot_bank  out  2  SDRAM bank ([1] always 0)
- boot_dout  out  8  write data
- rom_map  out  256  bit n set once expansion page n is written

Behaviour:
- Reset: state IDLE, ioctl_wait=0, boot_wr=0, boot_a=0, boot_bank=0, boot_dout=0, rom_map=0, page=0, combo=0.
- Download start: rising edge of ioctl_download (1-cycle registered edge) with ioctl_index!=0.
  - page=PAGE_BADEXT, combo=0.
  - Hex digit in ext[15:8] sets page[7:4]; hex digit in ext[7:0] sets page[3:0]. Only 0-9 and upper-case A-F are valid.
  - "ZZ" sets page=0. "Z0" sets page=0 and combo=1.
- FSM states: IDLE, ARM, WR.
- IDLE, on ioctl_download & ioctl_wr:
  - Latch boot_dout=ioctl_dout and boot_a[13:0]=ioctl_addr[13:0].
  - Index!=0: boot_a[22]=page[8]; boot_a[21:14]=page[7:0]+ioctl_addr[21:14] mod 256; boot_bank=&ioctl_index[7:6]. Assert ioctl_wait and go to ARM.
  - Index 0: addr[24:14] of 0/4 maps to page 000, 1/5 to 100, 2/6 to 107, 3/7 to PAGE_MF2. Pages 0-3 use bank 0; pages 4-7 use bank 1. Any addr[24:14]>7 drops the byte: stay IDLE, ioctl_wait stays 0.
- ARM, on ce_ref: boot_wr=1, go to WR.
- WR, on ce_ref: boot_wr=0.
  - Duplicate condition: (ioctl_index[7:6]==1 or ioctl_index[5:0]!=0) and boot_bank==0. When true, set boot_bank=1 and return to ARM.
  - Otherwise:
    - Set ioctl_wait=0 and go to IDLE.
    - If boot_a[22], set rom_map[boot_a[21:14]].
    - If combo and boot_a[13:0]==14'h3FFF, set combo=0 and page=PAGE_MF2.
- Each write holds boot_wr for exactly one ce_ref period. Worst case is 4 ce_ref periods per byte, with 2 SDRAM writes.
- ioctl_wr arriving outside IDLE is ignored; the HPS respects ioctl_wait.
- Download dropping mid-write: the sequence completes normally.
- reset mid-operation: immediate return to IDLE with all outputs at reset values. The interrupted byte is lost.
- rom_map persists across downloads and is cleared only by reset.

Optional Feature:
- Macro ROMLOAD_CHECKSUM_EN.
- Defined:
  - Extra outputs rom_sum[15:0] and rom_bytes[24:0], both cleared at download start.
  - On every accepted byte (IDLE to ARM), rom_sum += ioctl_dout (mod 2^16) and rom_bytes += 1.
  - Both are reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Index 0, 4 bytes at addr 0x04000 (0x11,0x22,0x33,0x44): 4 writes boot_a=0x400000..0x400003, bank 0, one write each. Bytes at 0x1C000 go to page 1FF, bank 1. A byte at 0x20000 gives no write and ioctl_wait stays 0.
- Index 0x01, ext "e07", byte 0xA5 at addr 0: two writes, boot_a=0x41C000 bank 0 then bank 1. rom_map[7]=1 after the second write. ioctl_wait is high for exactly 4 ce_ref periods.
- Index 0xC1, ext "eFF": single write to bank 1, boot_a=0x7FC000, rom_map[255]=1.
- Ext "eZ0", 32 KiB file: first 16 KiB written to page 000. After the byte at 0x3FFF, page=1FF. Byte 0x4000 is written to boot_a=0x400000 (page 0x100), and rom_map[0]=1.
- Ext "eG1" (malformed high digit): page=1E1, writes to 0x784000-range, rom_map[0xE1] set. Ext "eXY": page 1EE.
- Assert reset while in ARM: next cycle boot_wr=0, ioctl_wait=0, rom_map=0, state IDLE. With ROMLOAD_CHECKSUM_EN, bytes 0xFF,0x02 give rom_sum=0x0101 and rom_bytes=2.

Source files
------------

// File: rtl/cpc_rom_loader_if.sv
// Download stream from the HPS and the SDRAM boot write port
interface cpc_rom_loader_if;
   logic         ioctl_download;
   logic         ioctl_wr;
   logic [24:0]  ioctl_addr;
   logic [7:0]   ioctl_dout;
   logic [7:0]   ioctl_index;
   logic [31:0]  ioctl_file_ext;
   logic         ioctl_wait;
   logic         boot_wr;
   logic [22:0]  boot_a;
   logic [1:0]   boot_bank;
   logic [7:0]   boot_dout;
   logic [255:0] rom_map;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr,
      output ioctl_dout, ioctl_index, ioctl_file_ext,
      input  ioctl_wait, boot_wr, boot_a,
      input  boot_bank, boot_dout, rom_map
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr,
      input  ioctl_dout, ioctl_index, ioctl_file_ext,
      output ioctl_wait, boot_wr, boot_a,
      output boot_bank, boot_dout, rom_map
   );
endinterface

// File: rtl/cpc_rom_loader.sv
// ROM download to SDRAM write sequencer with expansion page map.
// Optional ROMLOAD_CHECKSUM_EN adds rom_sum/rom_bytes outputs.
module cpc_rom_loader #(
   parameter logic [8:0] PAGE_BADEXT = 9'h1EE,
   parameter logic [8:0] PAGE_MF2    = 9'h1FF
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic ce_ref,
`ifdef ROMLOAD_CHECKSUM_EN
   output logic [15:0] rom_sum,
   output logic [24:0] rom_bytes,
`endif
   cpc_rom_loader_if.slave io
);

   typedef enum logic [1:0] {IDLE, ARM, WR} state_t;

   state_t         state, state_n;
   logic           wait_q, wait_n;
   logic           wr_q, wr_n;
   logic [22:0]    a_q, a_n;
   logic [1:0]     bank_q, bank_n;
   logic [7:0]     dout_q, dout_n;
   logic [255:0]   map_q, map_n;
   logic [8:0]     page_q, page_n;
   logic           combo_q, combo_n;
   logic           dl_q;

   logic           start, accept, dup;
   logic [4:0]     hi, lo;
   logic [10:0]    sel;
   logic [7:0]     ext_h, ext_l;

   function automatic logic [4:0] hex_dig(input logic [7:0] c);
      if (c >= "0" && c <= "9")
         return {1'b1, c[3:0]};
      else if (c >= "A" && c <= "F")
         return {1'b1, 4'(c[3:0] + 4'd9)};
      else
         return 5'd0;
   endfunction

   assign ext_h = io.ioctl_file_ext[15:8];
   assign ext_l = io.ioctl_file_ext[7:0];
   assign hi    = hex_dig(ext_h);
   assign lo    = hex_dig(ext_l);
   assign sel   = io.ioctl_addr[24:14];
   assign start = io.ioctl_download & ~dl_q
                & (io.ioctl_index != 8'd0);
   assign dup   = (io.ioctl_index[7:6] == 2'b01
                || io.ioctl_index[5:0] != 6'd0)
                && bank_q == 2'b00;

   always_comb begin
      state_n = state;
      wait_n  = wait_q;
      wr_n    = wr_q;
      a_n     = a_q;
      bank_n  = bank_q;
      dout_n  = dout_q;
      map_n   = map_q;
      page_n  = page_q;
      combo_n = combo_q;
      accept  = 1'b0;
      unique case (state)
         IDLE: begin
            if (io.ioctl_download && io.ioctl_wr) begin
               dout_n     = io.ioctl_dout;
               a_n[13:0]  = io.ioctl_addr[13:0];
               if (io.ioctl_index != 8'd0) begin
                  a_n[22]    = page_q[8];
                  a_n[21:14] = page_q[7:0] + io.ioctl_addr[21:14];
                  bank_n     = {1'b0, &io.ioctl_index[7:6]};
                  accept     = 1'b1;
               end else if (sel < 11'd8) begin
                  case (sel[1:0])
                     2'd0:    a_n[22:14] = 9'h000;
                     2'd1:    a_n[22:14] = 9'h100;
                     2'd2:    a_n[22:14] = 9'h107;
                     default: a_n[22:14] = PAGE_MF2;
                  endcase
                  bank_n = {1'b0, sel[2]};
                  accept = 1'b1;
               end
               if (accept) begin
                  wait_n  = 1'b1;
                  state_n = ARM;
               end
            end
         end
         ARM: begin
            if (ce_ref) begin
               wr_n    = 1'b1;
               state_n = WR;
            end
         end
         WR: begin
            if (ce_ref) begin
               wr_n = 1'b0;
               if (dup) begin
                  bank_n  = 2'b01;
                  state_n = ARM;
               end else begin
                  wait_n  = 1'b0;
                  state_n = IDLE;
                  if (a_q[22])
                     map_n[a_q[21:14]] = 1'b1;
                  // Z0 combo: after the first 16 KiB, continue at MF2 page
                  if (combo_q && a_q[13:0] == 14'h3FFF) begin
                     combo_n = 1'b0;
                     page_n  = PAGE_MF2;
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (start) begin
         page_n  = PAGE_BADEXT;
         combo_n = 1'b0;
         if (hi[4]) page_n[7:4] = hi[3:0];
         if (lo[4]) page_n[3:0] = lo[3:0];
         if (ext_h == "Z" && ext_l == "Z")
            page_n = 9'h000;
         if (ext_h == "Z" && ext_l == "0") begin
            page_n  = 9'h000;
            combo_n = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state   <= IDLE;
         wait_q  <= 1'b0;
         wr_q    <= 1'b0;
         a_q     <= '0;
         bank_q  <= '0;
         dout_q  <= '0;
         map_q   <= '0;
         page_q  <= '0;
         combo_q <= 1'b0;
         dl_q    <= 1'b0;
      end else begin
         state   <= state_n;
         wait_q  <= wait_n;
         wr_q    <= wr_n;
         a_q     <= a_n;
         bank_q  <= bank_n;
         dout_q  <= dout_n;
         map_q   <= map_n;
         page_q  <= page_n;
         combo_q <= combo_n;
         dl_q    <= io.ioctl_download;
      end
   end

`ifdef ROMLOAD_CHECKSUM_EN
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rom_sum   <= '0;
         rom_bytes <= '0;
      end else if (start) begin
         rom_sum   <= '0;
         rom_bytes <= '0;
      end else if (accept) begin
         rom_sum   <= rom_sum + {8'h00, io.ioctl_dout};
         rom_bytes <= rom_bytes + 25'd1;
      end
   end
`endif

   assign io.ioctl_wait = wait_q;
   assign io.boot_wr    = wr_q;
   assign io.boot_a     = a_q;
   assign io.boot_bank  = bank_q;
   assign io.boot_dout  = dout_q;
   assign io.rom_map    = map_q;

endmodule
